// File: rtl/trng_collector.sv
// trng_collector: gathers serial bits from the ring-oscillator generator into
// 32-bit random words. After reset it discards a warm-up run of raw samples,
// then collects bits into a holding register with single-cycle pop. A
// repetition health test on the raw stream raises a sticky failure flag and
// throws away any partial word.
// Optional feature: define TRNG_VON_NEUMANN_EN to debias the collected stream
// with a Von Neumann corrector (raw pairs 10 -> 1, 01 -> 0, 00/11 dropped).
module trng_collector #(
    parameter int WARMUP_BITS = 64,
    parameter int REP_LIMIT   = 24
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEn,
    input  logic        iSerial,
    output logic        oGenEn,
    input  logic        iRead,
    output logic [31:0] oData,
    output logic        oValid,
    output logic        oHealthFail,
    input  logic        iClearFail
);

    localparam int WW = $clog2(WARMUP_BITS + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        COLLECT = 2'd1,
        STALL   = 2'd2
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [WW-1:0]   warmCnt;
    logic [RW-1:0]   runCnt;
    logic [RW-1:0]   runNext;
    logic            lastBit;
    logic [31:0]     shiftReg;
    logic [31:0]     shiftNext;
    logic [5:0]      bitCnt;
    logic            sampleEn;
    logic            trip;
    logic            accValid;
    logic            accVal;
    logic            wordDone;
    logic            warmDone;

`ifdef TRNG_VON_NEUMANN_EN
    logic            vnHave;
    logic            vnFirst;
`endif

    // Raw sampling happens only while the generator is enabled.
    assign sampleEn = iEn && (state != STALL);
    assign oGenEn   = sampleEn;
    assign warmDone = (warmCnt == WW'(WARMUP_BITS - 1));

    // Repetition run length including the current sample, and the trip strobe.
    always_comb begin
        runNext = RW'(1);
        if (runCnt != '0 && iSerial == lastBit) begin
            runNext = runCnt + RW'(1);
        end
    end
    assign trip = sampleEn && (runNext == RW'(REP_LIMIT));

    // Accepted-bit selection: either every collected raw sample or the
    // Von Neumann output of a completed unequal pair.
    always_comb begin
        accValid = 1'b0;
        accVal   = iSerial;
`ifdef TRNG_VON_NEUMANN_EN
        if (sampleEn && state == COLLECT && vnHave && (vnFirst != iSerial)) begin
            accValid = 1'b1;
            accVal   = vnFirst;
        end
`else
        if (sampleEn && state == COLLECT) begin
            accValid = 1'b1;
        end
`endif
    end

    assign shiftNext = {shiftReg[30:0], accVal};
    // A health trip on the completing edge discards the word instead.
    assign wordDone  = accValid && !trip && (bitCnt == 6'd31);

    // Next-state logic for warm-up / collect / stall.
    always_comb begin
        stateNext = state;
        unique case (state)
            WARMUP: begin
                if (sampleEn && warmDone) begin
                    stateNext = COLLECT;
                end
            end
            COLLECT: begin
                if (wordDone && oValid && !iRead) begin
                    stateNext = STALL;
                end
            end
            STALL: begin
                if (iRead) begin
                    stateNext = COLLECT;
                end
            end
            default: stateNext = WARMUP;
        endcase
    end

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= WARMUP;
        end else begin
            state <= stateNext;
        end
    end

    // Warm-up sample counter.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            warmCnt <= '0;
        end else if (sampleEn && state == WARMUP) begin
            warmCnt <= warmCnt + WW'(1);
        end
    end

    // Repetition run tracker; a trip restarts the run on the next sample.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            runCnt  <= '0;
            lastBit <= 1'b0;
        end else if (sampleEn) begin
            lastBit <= iSerial;
            runCnt  <= trip ? '0 : runNext;
        end
    end

    // Sticky health flag; a trip beats a simultaneous clear.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oHealthFail <= 1'b0;
        end else if (trip) begin
            oHealthFail <= 1'b1;
        end else if (iClearFail) begin
            oHealthFail <= 1'b0;
        end
    end

`ifdef TRNG_VON_NEUMANN_EN
    // Von Neumann pair buffer; half pairs are dropped on a trip or outside COLLECT.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            vnHave  <= 1'b0;
            vnFirst <= 1'b0;
        end else if (trip || state != COLLECT) begin
            vnHave <= 1'b0;
        end else if (sampleEn) begin
            if (!vnHave) begin
                vnHave  <= 1'b1;
                vnFirst <= iSerial;
            end else begin
                vnHave <= 1'b0;
            end
        end
    end
`endif

    // Shift register and bit counter; count 32 marks a full word waiting in STALL.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            shiftReg <= '0;
            bitCnt   <= '0;
        end else if (trip) begin
            bitCnt <= '0;
        end else if (state == STALL && iRead) begin
            bitCnt <= '0;
        end else if (accValid) begin
            shiftReg <= shiftNext;
            if (bitCnt == 6'd31) begin
                bitCnt <= (!oValid || iRead) ? 6'd0 : 6'd32;
            end else begin
                bitCnt <= bitCnt + 6'd1;
            end
        end
    end

    // Holding register: load on word completion or stall release, clear on pop.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oData  <= '0;
            oValid <= 1'b0;
        end else if (wordDone && (!oValid || iRead)) begin
            oData  <= shiftNext;
            oValid <= 1'b1;
        end else if (state == STALL && iRead) begin
            oData  <= shiftReg;
            oValid <= 1'b1;
        end else if (iRead && oValid) begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector. Build with +define+TRNG_VON_NEUMANN_EN
// to exercise the debiasing variant instead of the plain collection tests.
module tb_trng_collector;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iEn;
    logic        iSerial;
    logic        oGenEn;
    logic        iRead;
    logic [31:0] oData;
    logic        oValid;
    logic        oHealthFail;
    logic        iClearFail;

    int nCmp = 0;
    int nErr = 0;

    trng_collector #(.WARMUP_BITS(64), .REP_LIMIT(24)) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iEn         (iEn),
        .iSerial     (iSerial),
        .oGenEn      (oGenEn),
        .iRead       (iRead),
        .oData       (oData),
        .oValid      (oValid),
        .oHealthFail (oHealthFail),
        .iClearFail  (iClearFail)
    );

    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic feed(input logic b);
        iSerial = b;
        tick();
    endtask

    // Alternating pattern indexed from sample startIdx: even index -> 1.
    task automatic feedAlt(input int n, input int startIdx);
        for (int i = 0; i < n; i++) begin
            feed(((startIdx + i) % 2) == 0);
        end
    endtask

    task automatic feedBits(input logic [31:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            feed(w[i]);
        end
    endtask

    task automatic doReset();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        iRst = 1'b1; iEn = 1'b1; iSerial = 1'b0; iRead = 1'b0; iClearFail = 1'b0;
        tick();
        tick();
        checkVal("rst_valid", oValid, 0);
        checkVal("rst_data", oData, 32'h0);
        checkVal("rst_hfail", oHealthFail, 0);
        checkVal("rst_genen", oGenEn, 1);
        iRst = 1'b0;

        // Repetition test on a stuck-at-1 stream during warm-up.
        for (int i = 0; i < 23; i++) feed(1'b1);
        checkVal("hf_before_trip", oHealthFail, 0);
        feed(1'b1);
        checkVal("hf_trip_run24", oHealthFail, 1);
        iClearFail = 1'b1;
        feed(1'b1);
        iClearFail = 1'b0;
        checkVal("hf_cleared", oHealthFail, 0);
        for (int i = 0; i < 22; i++) feed(1'b1);
        checkVal("hf_run23_again", oHealthFail, 0);
        iClearFail = 1'b1;
        feed(1'b1);
        iClearFail = 1'b0;
        checkVal("hf_set_beats_clear", oHealthFail, 1);

`ifdef TRNG_VON_NEUMANN_EN
        doReset();
        feedAlt(64, 0);
        for (int i = 0; i < 63; i++) feed((i % 4 == 0) || (i % 4 == 3));
        checkVal("vn_valid_early", oValid, 0);
        feed(1'b1);
        checkVal("vn_valid", oValid, 1);
        checkVal("vn_data", oData, 32'hAAAAAAAA);
        iEn = 1'b0; iRead = 1'b1;
        tick();
        iRead = 1'b0; iEn = 1'b1;
        checkVal("vn_pop", oValid, 0);
        // 00/11 pairs must be dropped, then 01,10 pairs yield 0,1,...
        for (int i = 0; i < 8; i++) feed((i % 4) < 2);
        for (int i = 0; i < 64; i++) feed((i % 4 == 1) || (i % 4 == 2));
        checkVal("vn_valid2", oValid, 1);
        checkVal("vn_data2", oData, 32'h55555555);
`else
        // First word after warm-up, then stall on the unread second word.
        doReset();
        feedAlt(95, 0);
        checkVal("valid_early", oValid, 0);
        feedAlt(1, 95);
        checkVal("valid_s95", oValid, 1);
        checkVal("data_s95", oData, 32'hAAAAAAAA);
        checkVal("hf_s95", oHealthFail, 0);
        feedAlt(31, 96);
        checkVal("genen_pre_stall", oGenEn, 1);
        feedAlt(1, 127);
        checkVal("genen_stall", oGenEn, 0);
        checkVal("valid_stall", oValid, 1);
        tick();
        checkVal("genen_stall_hold", oGenEn, 0);
        iRead = 1'b1;
        tick();
        iRead = 1'b0;
        checkVal("data_reload", oData, 32'hAAAAAAAA);
        checkVal("valid_reload", oValid, 1);
        checkVal("genen_resume", oGenEn, 1);

        // Pop with iEn low clears oValid; a second pop is ignored.
        iEn = 1'b0; iRead = 1'b1;
        tick();
        checkVal("pop_valid", oValid, 0);
        checkVal("pop_data_hold", oData, 32'hAAAAAAAA);
        tick();
        iRead = 1'b0; iEn = 1'b1;
        checkVal("pop_empty_ignored", oValid, 0);

        // Pause mid-word: garbage on iSerial while disabled must not enter.
        w = 32'h3C5A96F0;
        feedBits(w, 31, 16);
        iEn = 1'b0;
        for (int i = 0; i < 10; i++) feed(i[0]);
        checkVal("genen_paused", oGenEn, 0);
        iEn = 1'b1;
        feedBits(w, 15, 1);
        checkVal("pause_valid_early", oValid, 0);
        feedBits(w, 0, 0);
        checkVal("pause_valid", oValid, 1);
        checkVal("pause_data", oData, 32'h3C5A96F0);

        // Reset with a held word and a partial word.
        feedAlt(20, 0);
        checkVal("mid_valid", oValid, 1);
        doReset();
        checkVal("mid_rst_valid", oValid, 0);
        checkVal("mid_rst_data", oData, 32'h0);
        feedAlt(95, 0);
        checkVal("after_rst_early", oValid, 0);
        feedAlt(1, 95);
        checkVal("after_rst_valid", oValid, 1);
        checkVal("after_rst_data", oData, 32'hAAAAAAAA);

        // Trip during collection discards the partial word.
        doReset();
        feedAlt(64, 0);
        feedAlt(4, 64);
        for (int i = 0; i < 23; i++) feed(1'b1);
        checkVal("col_hf_before", oHealthFail, 0);
        feed(1'b1);
        checkVal("col_hf_trip", oHealthFail, 1);
        w = 32'h55555555;
        feedBits(w, 31, 1);
        checkVal("col_discard_early", oValid, 0);
        feedBits(w, 0, 0);
        checkVal("col_discard_valid", oValid, 1);
        checkVal("col_discard_data", oData, 32'h55555555);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
